// File: rtl/game_pkg.sv
// Shared constants and state encoding for the block-stacking game pipeline.
// Reused by the shifter, the stack resolver and the display.
package game_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROWS = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_INIT_BLOCK = 8'b11100000;
  localparam int DEF_LEVEL_W = $clog2(DEF_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_COMMIT,
    S_LOSE,
    S_WIN
  } state_t;

endpackage

// File: rtl/stack_mem.sv
// ROWS x WIDTH register file holding the committed stack.
// One write port, a synchronous clear, and the whole array visible as a flat bus.
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int ROWS = 8,
  parameter int AW = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [ROWS*WIDTH-1:0] rdata_flat
);

  logic [ROWS*WIDTH-1:0] mem_q, mem_d;

  // Clear wins over a write in the same cycle so a restart never keeps a stale row.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else if (we) begin
      mem_d[addr*WIDTH +: WIDTH] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_flat = mem_q;

endmodule

// File: rtl/stack_resolver.sv
// Trims a frozen row against the row beneath it, commits it to the stack,
// advances the level and hands the trimmed pattern back to the shifter.
module stack_resolver import game_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ROWS = DEF_ROWS,
  parameter logic [WIDTH-1:0] INIT_BLOCK = DEF_INIT_BLOCK
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     startBtn,
  input  logic [WIDTH-1:0]         rowIn,
  input  logic                     rowValid,
  output logic [WIDTH-1:0]         nextBlock,
  output logic                     nextLoad,
  output logic [$clog2(ROWS)-1:0]  level,
  output logic [ROWS*WIDTH-1:0]    stackFlat,
  output logic                     busy,
  output logic                     gameOver,
  output logic                     gameWon,
  output state_t                   stateDbg
);

  localparam int LW = $clog2(ROWS);

  // Handshake: rowValid is a one-cycle pulse with no back-pressure. It is
  // accepted only in PLAY; in any other state (including CHECK/COMMIT) it is
  // dropped. nextLoad is a one-cycle pulse the shifter must act on.

  state_t           state_q, state_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] next_block_q, next_block_d;
  logic [WIDTH-1:0] captured_q, captured_d;
  logic [WIDTH-1:0] trimmed_q, trimmed_d;
  logic             next_load_q, next_load_d;
  logic             game_over_q, game_over_d;
  logic             game_won_q, game_won_d;

  logic             mem_clr, mem_we;
  logic [LW-1:0]    prev_level;
  logic [WIDTH-1:0] below_row;

  // prev_level wraps at level 0, but the row below is ignored there.
  assign prev_level = level_q - LW'(1);
  assign below_row  = stackFlat[prev_level*WIDTH +: WIDTH];

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    next_block_d = next_block_q;
    captured_d   = captured_q;
    trimmed_d    = trimmed_q;
    next_load_d  = 1'b0;
    game_over_d  = game_over_q;
    game_won_d   = game_won_q;
    mem_clr      = 1'b0;
    mem_we       = 1'b0;

    if (startBtn) begin
      mem_clr      = 1'b1;
      level_d      = '0;
      next_block_d = INIT_BLOCK;
      game_over_d  = 1'b0;
      game_won_d   = 1'b0;
      next_load_d  = 1'b1;
      state_d      = S_PLAY;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (rowValid) begin
            captured_d = rowIn;
            state_d    = S_CHECK;
          end
        end
        S_CHECK: begin
          trimmed_d = (level_q == '0) ? captured_q : (captured_q & below_row);
          state_d   = S_COMMIT;
        end
        S_COMMIT: begin
          if (trimmed_q == '0) begin
            game_over_d = 1'b1;
            state_d     = S_LOSE;
          end else begin
            mem_we = 1'b1;
            if (level_q == LW'(ROWS - 1)) begin
              game_won_d = 1'b1;
              state_d    = S_WIN;
            end else begin
              level_d      = level_q + LW'(1);
              next_block_d = trimmed_q;
              next_load_d  = 1'b1;
              state_d      = S_PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      level_q      <= '0;
      next_block_q <= '0;
      captured_q   <= '0;
      trimmed_q    <= '0;
      next_load_q  <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      next_block_q <= next_block_d;
      captured_q   <= captured_d;
      trimmed_q    <= trimmed_d;
      next_load_q  <= next_load_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  stack_mem #(
    .WIDTH(WIDTH),
    .ROWS (ROWS),
    .AW   (LW)
  ) u_stack_mem (
    .clk       (clk),
    .rst_n     (rstN),
    .clr       (mem_clr),
    .we        (mem_we),
    .addr      (level_q),
    .wdata     (trimmed_q),
    .rdata_flat(stackFlat)
  );

  assign nextBlock = next_block_q;
  assign nextLoad  = next_load_q;
  assign level     = level_q;
  assign busy      = (state_q == S_CHECK) || (state_q == S_COMMIT);
  assign gameOver  = game_over_q;
  assign gameWon   = game_won_q;
  assign stateDbg  = state_q;

endmodule

// File: tb/tb_stack_resolver.sv
// Bench for stack_resolver: transaction-level model with per-cycle compare,
// directed game scenarios with literal expectations, then random play.
module tb_stack_resolver;
  import game_pkg::*;

  localparam int W = 8;
  localparam int R = 8;
  localparam logic [W-1:0] INIT = 8'b11100000;

  logic             clk = 1'b0;
  logic             rstN;
  logic             startBtn;
  logic [W-1:0]     rowIn;
  logic             rowValid;
  logic [W-1:0]     nextBlock;
  logic             nextLoad;
  logic [2:0]       level;
  logic [R*W-1:0]   stackFlat;
  logic             busy;
  logic             gameOver;
  logic             gameWon;
  state_t           stateDbg;

  stack_resolver dut (
    .clk      (clk),
    .rstN     (rstN),
    .startBtn (startBtn),
    .rowIn    (rowIn),
    .rowValid (rowValid),
    .nextBlock(nextBlock),
    .nextLoad (nextLoad),
    .level    (level),
    .stackFlat(stackFlat),
    .busy     (busy),
    .gameOver (gameOver),
    .gameWon  (gameWon),
    .stateDbg (stateDbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A row accepted in play resolves two edges later; its outcome is computed
  // from the rules at acceptance and applied when the countdown expires.
  logic [W-1:0] m_stack[R];
  int           m_level;
  logic [W-1:0] m_block;
  bit           m_load, m_over, m_won, m_playing;
  int           m_busy_left;
  logic [W-1:0] m_trim;

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < R; r++) f[r*W +: W] = m_stack[r];
    return f;
  endfunction

  task automatic model_clear_game();
    for (int r = 0; r < R; r++) m_stack[r] = '0;
    m_level = 0;
    m_over = 0;
    m_won = 0;
    m_busy_left = 0;
  endtask

  initial begin
    model_clear_game();
    m_block = '0;
    m_load = 0;
    m_playing = 0;
    m_trim = '0;
    forever begin
      @(posedge clk);
      if (!rstN) begin
        model_clear_game();
        m_block = '0;
        m_load = 0;
        m_playing = 0;
      end else if (startBtn) begin
        model_clear_game();
        m_block = INIT;
        m_load = 1;
        m_playing = 1;
      end else begin
        m_load = 0;
        if (m_busy_left > 0) begin
          m_busy_left--;
          if (m_busy_left == 0) begin
            if (m_trim == '0) begin
              m_over = 1;
              m_playing = 0;
            end else begin
              m_stack[m_level] = m_trim;
              if (m_level == R - 1) begin
                m_won = 1;
                m_playing = 0;
              end else begin
                m_level++;
                m_block = m_trim;
                m_load = 1;
              end
            end
          end
        end else if (m_playing && rowValid) begin
          m_trim = (m_level == 0) ? rowIn : (rowIn & m_stack[m_level-1]);
          m_busy_left = 2;
        end
      end
      #1;
      check("nextBlock", 64'(nextBlock), 64'(m_block));
      check("nextLoad", 64'(nextLoad), 64'(m_load));
      check("level", 64'(level), 64'(m_level));
      check("stackFlat", stackFlat, model_flat());
      check("busy", 64'(busy), 64'(m_busy_left > 0));
      check("gameOver", 64'(gameOver), 64'(m_over));
      check("gameWon", 64'(gameWon), 64'(m_won));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk);
    startBtn = 1'b1;
    @(negedge clk);
    startBtn = 1'b0;
  endtask

  task automatic send_row(input logic [W-1:0] r);
    @(negedge clk);
    rowValid = 1'b1;
    rowIn = r;
    @(negedge clk);
    rowValid = 1'b0;
  endtask

  // Ends at the negedge after the commit edge, where nextLoad would be visible.
  task automatic play_row(input logic [W-1:0] r);
    send_row(r);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_row();
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 255));
      1: return m_block;
      2: return m_block >> 1;
      default: return m_block << 1;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rstN = 1'b0;
    startBtn = 1'b0;
    rowValid = 1'b0;
    rowIn = '0;
    repeat (3) @(negedge clk);
    check("rst_nextLoad", 64'(nextLoad), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stack", stackFlat, 64'd0);
    check("rst_nextBlock", 64'(nextBlock), 64'd0);
    rstN = 1'b1;

    do_start();
    check("start_nextLoad", 64'(nextLoad), 64'd1);
    check("start_nextBlock", 64'(nextBlock), 64'hE0);
    check("start_level", 64'(level), 64'd0);
    check("start_stack", stackFlat, 64'd0);
    @(negedge clk);
    check("start_pulse_len", 64'(nextLoad), 64'd0);

    play_row(8'b00111000);
    check("l0_nextLoad", 64'(nextLoad), 64'd1);
    check("l0_nextBlock", 64'(nextBlock), 64'h38);
    check("l0_stack0", 64'(stackFlat[7:0]), 64'h38);
    check("l0_level", 64'(level), 64'd1);
    check("model_pin_stack0", 64'(m_stack[0]), 64'h38);

    play_row(8'b00011100);
    check("l1_stack1", 64'(stackFlat[15:8]), 64'h18);
    check("l1_nextBlock", 64'(nextBlock), 64'h18);
    check("l1_level", 64'(level), 64'd2);
    check("model_pin_block", 64'(m_block), 64'h18);

    play_row(8'b00000011);
    check("miss_gameOver", 64'(gameOver), 64'd1);
    check("miss_nextLoad", 64'(nextLoad), 64'd0);
    check("miss_stack2", 64'(stackFlat[23:16]), 64'd0);
    play_row(8'hFF);
    check("lose_hold_over", 64'(gameOver), 64'd1);
    check("lose_hold_stack", stackFlat, 64'h0000_0000_0000_1838);

    // Start and rowValid together: restart only.
    @(negedge clk);
    startBtn = 1'b1;
    rowValid = 1'b1;
    rowIn = 8'hFF;
    @(negedge clk);
    startBtn = 1'b0;
    rowValid = 1'b0;
    check("restart_nextLoad", 64'(nextLoad), 64'd1);
    check("restart_busy", 64'(busy), 64'd0);
    check("restart_stack", stackFlat, 64'd0);
    check("restart_over", 64'(gameOver), 64'd0);

    // Back-to-back rowValid while busy must be dropped.
    @(negedge clk);
    rowValid = 1'b1;
    rowIn = 8'hE0;
    @(negedge clk);
    rowIn = 8'h07;
    @(negedge clk);
    rowIn = 8'h0F;
    @(negedge clk);
    rowValid = 1'b0;
    check("busy_drop_stack0", 64'(stackFlat[7:0]), 64'hE0);
    check("busy_drop_level", 64'(level), 64'd1);
    check("busy_drop_load", 64'(nextLoad), 64'd1);

    // Empty row at level 0 loses immediately.
    do_start();
    play_row(8'h00);
    check("zero_row_over", 64'(gameOver), 64'd1);
    check("zero_row_stack", stackFlat, 64'd0);

    // Perfect stacking to the top.
    do_start();
    repeat (R) play_row(8'b11100000);
    check("win_gameWon", 64'(gameWon), 64'd1);
    check("win_stack", stackFlat, 64'hE0E0_E0E0_E0E0_E0E0);
    check("win_no_load", 64'(nextLoad), 64'd0);
    check("win_level", 64'(level), 64'd7);
    repeat (2) @(negedge clk);
    check("win_hold", 64'(gameWon), 64'd1);

    // Reset during COMMIT.
    do_start();
    send_row(8'hE0);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_nextBlock", 64'(nextBlock), 64'd0);
    check("arst_stack", stackFlat, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("arst_after_stack", stackFlat, 64'd0);

    // Random play.
    do_start();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      startBtn = ($urandom_range(0, 99) == 0) ||
                 ((m_over || m_won) && ($urandom_range(0, 5) == 0));
      rowValid = ($urandom_range(0, 2) == 0);
      rowIn = pick_row();
    end
    @(negedge clk);
    startBtn = 1'b0;
    rowValid = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_resolver.md
Name: stack_resolver

Overview:
- Downstream stage of the block shifter.
- Takes the row the shifter freezes when the player presses stop, trims any overhang against the row beneath it, and commits the result to the stack.
- Advances the level and hands the trimmed pattern back to the shifter as the next moving block.
- Detects game over (no overlap) and win (top row filled).

Parameters:
- WIDTH, 8, bits per row (matches shifter row width).
- ROWS, 8, stack height in rows.
- INIT_BLOCK, 8'b11100000, block pattern loaded at game start.

Ports:
- clk  in  1  system clock (shifter's adjusted clock pulse domain).
- rstN  in  1  reset, asynchronous, active-low.
- startBtn  in  1  synchronous one-cycle pulse; starts or restarts a game.
- rowIn  in  WIDTH  frozen row from the shifter.
- rowValid  in  1  one-cycle pulse; rowIn is final this cycle.
- nextBlock  out  WIDTH  pattern the shifter loads as its block location.
- nextLoad  out  1  one-cycle pulse; shifter must reload from nextBlock.
- level  out  $clog2(ROWS)  index of the row currently being played.
- stackFlat  out  ROWS*WIDTH  committed rows for display; row r occupies bits [r*WIDTH +: WIDTH].
- busy  out  1  high in CHECK/COMMIT.
- gameOver  out  1  sticky until start/reset.
- gameWon  out  1  sticky until start/reset.

Behaviour:
- Reset (rstN=0, async):
  - state=IDLE; stack, level, nextBlock, trimmed and captured registers cleared to 0.
  - nextLoad, busy, gameOver and gameWon are 0.
- States: IDLE, PLAY, CHECK, COMMIT, LOSE, WIN.
- startBtn, any state, highest priority:
  - Clear stack, level=0, nextBlock=INIT_BLOCK, gameOver=gameWon=0.
  - nextLoad=1 for the following cycle; next state PLAY.
  - A rowValid in the same cycle is ignored.
- IDLE: waits for startBtn; rowValid ignored.
- PLAY, rowValid=1 at edge k: capture rowIn; next state CHECK.
- CHECK, edge k+1:
  - level==0: trimmed = captured row.
  - Otherwise: trimmed = captured AND stack[level-1].
  - trimmed registered; next state COMMIT.
- COMMIT, edge k+2:
  - trimmed==0: stack unchanged, gameOver=1, next state LOSE.
  - Otherwise write stack[level]=trimmed, then:
    - level==ROWS-1: gameWon=1, next state WIN, no nextLoad.
    - Else level+1, nextBlock=trimmed, nextLoad=1 during cycle k+3, next state PLAY.
- Latency: rowValid to nextLoad is 3 cycles; stackFlat updates at edge k+2.
- rowValid outside PLAY, including back-to-back while busy, is dropped with no effect.
- LOSE and WIN are terminal until startBtn; outputs hold.
- nextLoad is never high for more than one consecutive cycle.
- Captured rowIn==0 at level 0 gives gameOver.
- Width never grows: popcount(nextBlock) never exceeds the previous value.
- Reset mid-CHECK/COMMIT aborts with no stack write.

Decomposition:
- Shared package (game_pkg): WIDTH, ROWS, INIT_BLOCK defaults; state enum; level width constant. The shifter and display reuse these.
- One sub-module, stack_mem: ROWS×WIDTH register file with async reset, synchronous clear, single write port (addr, data, we) and flattened read bus. Trim logic and FSM stay in stack_resolver.

Test Plan:
- Reset, then startBtn → nextLoad pulse 1 cycle, nextBlock=8'b11100000, level=0, stackFlat=0.
- Level 0: rowValid with rowIn=8'b00111000 → 3 cycles later nextLoad=1, nextBlock=8'b00111000, stack[0]=8'b00111000, level=1.
- Level 1: rowIn=8'b00011100 over stack[0]=8'b00111000 → stack[1]=8'b00011000, nextBlock=8'b00011000, level=2.
- No overlap: rowIn=8'b00000011 over 8'b00011000 → gameOver=1, no nextLoad, stack[2]=0; later rowValid ignored; startBtn clears all.
- Perfect stacking with ROWS=8 (rowIn=8'b11100000 eight times) → gameWon=1 after the 8th commit, stackFlat all rows 8'b11100000, no final nextLoad.
- Corner cases:
  - rowValid and startBtn in the same cycle → restart only.
  - rowValid during busy → dropped.
  - rstN low during COMMIT → all outputs 0 immediately, stack unchanged from cleared state.
